// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between CPU (0), DMA (1) and video (2) masters.
// Command/grant registered on the accepting edge; beat acks and read data return one edge after iRamAck.
module ram_port_arbiter #(
  parameter int TIMEOUT_CYC = 255,
  parameter int BEATS_B1    = 4,
  parameter int BEATS_B2    = 8
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [2:0]  iReq,
  input  logic [59:0] iAdr,
  input  logic [5:0]  iRW,
  input  logic [2:0]  iBW,
  input  logic [47:0] iWData,
  input  logic [5:0]  iBurst,
  input  logic        iRamAck,
  input  logic [31:0] iRamData,
  output logic [19:0] oRamAdr,
  output logic [1:0]  oRamRW,
  output logic        oRamBW,
  output logic [15:0] oRamData,
  output logic [1:0]  oRamBurst,
  output logic [2:0]  oGnt,
  output logic [2:0]  oAck,
  output logic [31:0] oData32,
  output logic [2:0]  oErr,
  output logic [1:0]  oOwner,
  output logic        oBusy
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [16:0] TO_LIM = 17'(TIMEOUT_CYC);

  state_t      state, stateNext;
  logic [1:0]  last;
  logic [3:0]  beatCnt, expBeats;
  logic [15:0] wdog;
  logic [2:0]  elig;
  logic        winVld;
  logic [1:0]  winIdx;
  logic [1:0]  winRW, winBurst;
  logic [3:0]  winBeats;
  logic        grant, ackBeat, lastBeat, timeout;
  logic [2:0]  ownerMask;

  // Port visited at position off of the search that begins just after base.
  function automatic logic [1:0] rrIdx(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off} + 3'd1;
    if (s >= 3'd3) s = s - 3'd3;
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_elig
    assign elig[k] = iReq[k] && (iRW[2*k +: 2] != 2'b00);
  end

  // Walk the search order backwards so the earliest eligible port overwrites the rest.
  always_comb begin
    winVld = 1'b0;
    winIdx = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (elig[rrIdx(last, 2'(i))]) begin
        winVld = 1'b1;
        winIdx = rrIdx(last, 2'(i));
      end
    end
  end

  always_comb begin
    winRW = iRW[2*winIdx +: 2];
    if (winRW[0]) winRW = 2'b01;
    winBurst = iBurst[2*winIdx +: 2];
    if (winRW[0] || winBurst == 2'd3) winBurst = 2'd0;
    case (winBurst)
      2'd1:    winBeats = 4'(BEATS_B1);
      2'd2:    winBeats = 4'(BEATS_B2);
      default: winBeats = 4'd1;
    endcase
  end

  assign ownerMask = 3'b001 << oOwner;
  assign oBusy     = (state == WAIT);

  always_ff @(posedge iClk) begin
    if (iRst) state <= IDLE;
    else      state <= stateNext;
  end

  // An ack on the expiry cycle takes priority over the watchdog.
  always_comb begin
    stateNext = state;
    grant     = 1'b0;
    ackBeat   = 1'b0;
    lastBeat  = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (winVld) begin
          grant     = 1'b1;
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (iRamAck) begin
          ackBeat = 1'b1;
          if (beatCnt + 4'd1 == expBeats) begin
            lastBeat  = 1'b1;
            stateNext = IDLE;
          end
        end else if (TIMEOUT_CYC != 0 && ({1'b0, wdog} + 17'd1 >= TO_LIM)) begin
          timeout   = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oRamAdr   <= '0;
      oRamRW    <= '0;
      oRamBW    <= 1'b0;
      oRamData  <= '0;
      oRamBurst <= '0;
      oGnt      <= '0;
      oAck      <= '0;
      oData32   <= '0;
      oErr      <= '0;
      oOwner    <= 2'd3;
      last      <= 2'd2;
      beatCnt   <= '0;
      expBeats  <= '0;
      wdog      <= '0;
    end else begin
      oRamRW    <= '0;
      oRamBurst <= '0;
      oGnt      <= '0;
      oAck      <= '0;
      oErr      <= '0;
      if (grant) begin
        oRamAdr   <= iAdr[20*winIdx +: 20];
        oRamBW    <= iBW[winIdx];
        oRamData  <= iWData[16*winIdx +: 16];
        oRamRW    <= winRW;
        oRamBurst <= winBurst;
        oGnt      <= 3'b001 << winIdx;
        oOwner    <= winIdx;
        last      <= winIdx;
        expBeats  <= winBeats;
        beatCnt   <= '0;
        wdog      <= '0;
      end
      if (ackBeat) begin
        oData32 <= iRamData;
        oAck    <= ownerMask;
        beatCnt <= beatCnt + 4'd1;
        wdog    <= '0;
      end else if (state == WAIT && wdog != 16'hFFFF) begin
        wdog <= wdog + 16'd1;
      end
      if (timeout) oErr <= ownerMask;
      if (lastBeat || timeout) oOwner <= 2'd3;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed and randomized checks of ram_port_arbiter against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_ram_port_arbiter;

  logic        iClk = 1'b0;
  logic        iRst;
  logic [2:0]  iReq;
  logic [59:0] iAdr;
  logic [5:0]  iRW;
  logic [2:0]  iBW;
  logic [47:0] iWData;
  logic [5:0]  iBurst;
  logic        iRamAck;
  logic [31:0] iRamData;
  logic [19:0] oRamAdr;
  logic [1:0]  oRamRW;
  logic        oRamBW;
  logic [15:0] oRamData;
  logic [1:0]  oRamBurst;
  logic [2:0]  oGnt, oAck, oErr;
  logic [31:0] oData32;
  logic [1:0]  oOwner;
  logic        oBusy;

  ram_port_arbiter #(.TIMEOUT_CYC(16), .BEATS_B1(4), .BEATS_B2(8)) dut (
    .iClk(iClk), .iRst(iRst), .iReq(iReq), .iAdr(iAdr), .iRW(iRW), .iBW(iBW),
    .iWData(iWData), .iBurst(iBurst), .iRamAck(iRamAck), .iRamData(iRamData),
    .oRamAdr(oRamAdr), .oRamRW(oRamRW), .oRamBW(oRamBW), .oRamData(oRamData),
    .oRamBurst(oRamBurst), .oGnt(oGnt), .oAck(oAck), .oData32(oData32),
    .oErr(oErr), .oOwner(oOwner), .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  int checks = 0, passes = 0, fails = 0;
  int mLast;
  logic [31:0] lastData;

  logic        pReq[3];
  logic [19:0] pAdr[3];
  logic [1:0]  pRW[3];
  logic        pBW[3];
  logic [15:0] pWD[3];
  logic [1:0]  pBurst[3];

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 3; k++) begin
      iReq[k]            = pReq[k];
      iAdr[20*k +: 20]   = pAdr[k];
      iRW[2*k +: 2]      = pRW[k];
      iBW[k]             = pBW[k];
      iWData[16*k +: 16] = pWD[k];
      iBurst[2*k +: 2]   = pBurst[k];
    end
  endtask

  task automatic setPort(input int k, input logic req, input logic [19:0] adr, input logic [1:0] rw,
                         input logic bw, input logic [15:0] wd, input logic [1:0] burst);
    pReq[k] = req; pAdr[k] = adr; pRW[k] = rw; pBW[k] = bw; pWD[k] = wd; pBurst[k] = burst;
    drive();
  endtask

  task automatic clearAll();
    for (int k = 0; k < 3; k++) pReq[k] = 1'b0;
    drive();
  endtask

  // Round-robin rule: first eligible port after the last winner, wrapping mod 3.
  function automatic int pickWinner();
    for (int i = 1; i <= 3; i++) begin
      int k;
      k = (mLast + i) % 3;
      if (pReq[k] && pRW[k] != 2'b00) return k;
    end
    return -1;
  endfunction

  task automatic expectGrant(input int k, input bit keep, output int nb);
    logic [1:0] erw, eb;
    erw = (pRW[k] == 2'b11) ? 2'b01 : pRW[k];
    eb  = (erw == 2'b01 || pBurst[k] == 2'd3) ? 2'd0 : pBurst[k];
    nb  = (eb == 2'd1) ? 4 : (eb == 2'd2) ? 8 : 1;
    chk("gnt", oGnt, 32'(1) << k);
    chk("ramAdr", oRamAdr, pAdr[k]);
    chk("ramRW", oRamRW, erw);
    chk("ramBurst", oRamBurst, eb);
    chk("ramBW", oRamBW, pBW[k]);
    chk("ramData", oRamData, pWD[k]);
    chk("owner", oOwner, k);
    chk("busy", oBusy, 1);
    mLast = k;
    if (!keep) begin
      pReq[k] = 1'b0;
      drive();
    end
  endtask

  task automatic runBeats(input int k, input int n, input bit rnd);
    logic [31:0] d;
    int st;
    for (int b = 0; b < n; b++) begin
      st = rnd ? int'($urandom_range(0, 2)) : 0;
      for (int s = 0; s < st; s++) begin
        tick();
        chk("ackStall", oAck, 0);
        chk("busyStall", oBusy, 1);
      end
      d = rnd ? $urandom : 32'(b);
      iRamAck = 1'b1; iRamData = d;
      tick();
      iRamAck = 1'b0;
      chk("ackBeat", oAck, 32'(1) << k);
      chk("ackData", oData32, d);
      chk("gntInWait", oGnt, 0);
      chk("errInWait", oErr, 0);
      chk("cmdPulse", {oRamRW, oRamBurst}, 0);
      lastData = d;
    end
    chk("ownerDone", oOwner, 3);
    chk("busyDone", oBusy, 0);
  endtask

  initial begin
    int w, nb;
    iRst = 1'b1; iRamAck = 1'b0; iRamData = '0;
    for (int k = 0; k < 3; k++) setPort(k, 0, '0, 2'b00, 0, '0, 2'd0);
    tick(); tick();
    chk("rstOwner", oOwner, 3);
    chk("rstBusy", oBusy, 0);
    chk("rstPulses", {oGnt, oAck, oErr, oRamRW, oRamBurst}, 0);
    chk("rstRamAdr", oRamAdr, 0);
    chk("rstRamData", oRamData, 0);
    chk("rstRamBW", oRamBW, 0);
    chk("rstData32", oData32, 0);
    iRst = 1'b0; mLast = 2; lastData = '0;

    // Single read, RAM answers three cycles after the command.
    setPort(0, 1, 20'h12345, 2'b10, 1, 16'h0000, 2'd0);
    tick(); expectGrant(0, 0, nb);
    tick();
    chk("rwOneCycle", oRamRW, 0);
    chk("gntOneCycle", oGnt, 0);
    tick();
    iRamAck = 1'b1; iRamData = 32'hDEADBEEF;
    tick();
    iRamAck = 1'b0;
    chk("singleAck", oAck, 3'b001);
    chk("singleData", oData32, 32'hDEADBEEF);
    chk("singleOwner", oOwner, 3);
    lastData = 32'hDEADBEEF;
    tick();
    chk("singleAckOnce", oAck, 0);

    // Eight-beat burst on port 2 while port 1 waits.
    setPort(2, 1, 20'hABCDE, 2'b10, 1, 16'h1111, 2'd2);
    tick(); expectGrant(2, 0, nb);
    chk("burstBeats", nb, 8);
    setPort(1, 1, 20'h00042, 2'b01, 0, 16'hBEEF, 2'd0);
    runBeats(2, nb, 0);
    tick(); expectGrant(1, 0, nb);
    runBeats(1, nb, 1);

    // Continuous single writes from all ports rotate fairly.
    for (int k = 0; k < 3; k++) setPort(k, 1, 20'(32'h100 * (k + 1)), 2'b01, 1, 16'(16'hA000 + k), 2'd0);
    for (int i = 0; i < 6; i++) begin
      w = pickWinner();
      tick(); expectGrant(w, 1, nb);
      runBeats(w, nb, 1);
    end
    clearAll();

    // RW=11 with a burst becomes a single write; RW=00 is never granted.
    setPort(1, 1, 20'h55555, 2'b11, 0, 16'h7777, 2'd2);
    setPort(0, 1, 20'h66666, 2'b00, 0, 16'h8888, 2'd1);
    tick(); expectGrant(1, 0, nb);
    runBeats(1, nb, 1);
    tick(); chk("rw00Ignored", oGnt, 0);
    tick(); chk("rw00Idle", oBusy, 0);
    clearAll();

    // Watchdog expiry, then a late ack that must be dropped.
    setPort(1, 1, 20'h0BEEF, 2'b10, 1, 16'h0, 2'd0);
    tick(); expectGrant(1, 0, nb);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("noErrYet", oErr, 0);
    end
    tick();
    chk("timeoutErr", oErr, 3'b010);
    chk("timeoutOwner", oOwner, 3);
    chk("timeoutIdle", oBusy, 0);
    iRamAck = 1'b1; iRamData = 32'h0BADF00D;
    tick();
    iRamAck = 1'b0;
    chk("lateAckIgnored", oAck, 0);
    chk("lateAckData", oData32, lastData);

    // Ack landing on the expiry cycle completes the access instead.
    setPort(1, 1, 20'h0CAFE, 2'b10, 1, 16'h0, 2'd0);
    tick(); expectGrant(1, 0, nb);
    for (int i = 1; i < 16; i++) tick();
    iRamAck = 1'b1; iRamData = 32'h12344321;
    tick();
    iRamAck = 1'b0;
    chk("edgeAck", oAck, 3'b010);
    chk("edgeNoErr", oErr, 0);
    chk("edgeOwner", oOwner, 3);

    // Reset in the middle of a burst.
    setPort(2, 1, 20'h77777, 2'b10, 0, 16'h0, 2'd2);
    w = pickWinner();
    tick(); expectGrant(w, 0, nb);
    for (int b = 0; b < 3; b++) begin
      iRamAck = 1'b1; iRamData = 32'(b + 100);
      tick();
      chk("preRstAck", oAck, 32'(1) << w);
    end
    iRst = 1'b1;
    tick();
    iRst = 1'b0; mLast = 2;
    chk("midRstAck", oAck, 0);
    chk("midRstOwner", oOwner, 3);
    chk("midRstBusy", oBusy, 0);
    chk("midRstData", oData32, 0);
    chk("midRstAdr", oRamAdr, 0);
    tick(); chk("postRstAck1", oAck, 0);
    tick(); chk("postRstAck2", oAck, 0);
    iRamAck = 1'b0;
    for (int k = 0; k < 3; k++) setPort(k, 1, 20'(32'h300 + k), 2'b10, 1, 16'h0, 2'd0);
    tick(); expectGrant(0, 0, nb);
    clearAll();
    runBeats(0, nb, 1);

    // Randomized requests checked against the round-robin model.
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 3; k++) begin
        pReq[k]   = 1'($urandom_range(0, 1));
        pAdr[k]   = 20'($urandom);
        pRW[k]    = 2'($urandom_range(0, 3));
        pBW[k]    = 1'($urandom_range(0, 1));
        pWD[k]    = 16'($urandom);
        pBurst[k] = 2'($urandom_range(0, 3));
      end
      drive();
      w = pickWinner();
      tick();
      if (w < 0) begin
        chk("rndNoGnt", oGnt, 0);
      end else begin
        expectGrant(w, 0, nb);
        clearAll();
        runBeats(w, nb, 1);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
